fp_alu_arbiter: RTL and testbench

Shares one set of floating-point units (multiplier, adder, divider, exponent) among `NUM_REQ` term accumulators. It round-robin arbitrates operation requests and issues one start pulse to the matching unit. It waits for that unit's ready, then returns the result to the winning requester. A watchdog converts a hung unit into an error response, so no requester stalls forever.

---
 rtl/fp_alu_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_fp_alu_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_arbiter.sv
// Round-robin share of one FP mult/add/div/exp unit set; ack at k+1, start at k+2, response L+1 cycles after start.
// One operation in flight; requests are only sampled in IDLE and a hung unit becomes an error response after TIMEOUT_CYCLES.
module fp_alu_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 4,
    parameter int OP_WIDTH       = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*OP_WIDTH-1:0]   req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_b,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_error,
    output logic                          mult_start,
    output logic                          add_start,
    output logic                          divide_start,
    output logic                          exponent_start,
    output logic [DATA_WIDTH-1:0]         operand_a,
    output logic [DATA_WIDTH-1:0]         operand_b,
    input  logic                          mult_data_ready,
    input  logic                          add_data_ready,
    input  logic                          divide_data_ready,
    input  logic                          exponent_data_ready,
    input  logic [DATA_WIDTH-1:0]         mult_result,
    input  logic [DATA_WIDTH-1:0]         add_result,
    input  logic [DATA_WIDTH-1:0]         divide_result,
    input  logic [DATA_WIDTH-1:0]         exponent_result,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [OP_WIDTH-1:0] OP_EXP   = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_DIV   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t                state, state_next;
    logic [IDX_W-1:0]      rr_ptr, rr_ptr_next;
    logic [IDX_W-1:0]      winner, winner_next;
    logic [OP_WIDTH-1:0]   op_q, op_next;
    logic [DATA_WIDTH-1:0] a_q, a_next, b_q, b_next;
    logic [TMR_W-1:0]      timer, timer_next;

    logic [NUM_REQ-1:0]    req_ack_next, resp_valid_next;
    logic [DATA_WIDTH-1:0] resp_data_next, operand_a_next, operand_b_next;
    logic                  resp_error_next, busy_next;
    logic                  mult_start_next, add_start_next, divide_start_next, exponent_start_next;

    logic                  found;
    logic [IDX_W-1:0]      pick;
    logic                  unit_ready;
    logic [DATA_WIDTH-1:0] unit_result;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int c;
        found = 1'b0;
        pick  = '0;
        c     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = int'(rr_ptr) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!found && req_valid[IDX_W'(c)]) begin
                found = 1'b1;
                pick  = IDX_W'(c);
            end
        end
    end

    // Only the unit that was started may complete the operation.
    always_comb begin
        unit_ready  = 1'b0;
        unit_result = '0;
        case (op_q)
            OP_EXP: begin
                unit_ready  = exponent_data_ready;
                unit_result = exponent_result;
            end
            OP_MUL: begin
                unit_ready  = mult_data_ready;
                unit_result = mult_result;
            end
            OP_DIV: begin
                unit_ready  = divide_data_ready;
                unit_result = divide_result;
            end
            OP_ADD, OP_SUB: begin
                unit_ready  = add_data_ready;
                unit_result = add_result;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next          = state;
        rr_ptr_next         = rr_ptr;
        winner_next         = winner;
        op_next             = op_q;
        a_next              = a_q;
        b_next              = b_q;
        timer_next          = timer;
        req_ack_next        = '0;
        resp_valid_next     = '0;
        resp_data_next      = resp_data;
        resp_error_next     = resp_error;
        operand_a_next      = operand_a;
        operand_b_next      = operand_b;
        mult_start_next     = 1'b0;
        add_start_next      = 1'b0;
        divide_start_next   = 1'b0;
        exponent_start_next = 1'b0;

        case (state)
            S_IDLE: begin
                if (found) begin
                    winner_next        = pick;
                    op_next            = req_op[pick*OP_WIDTH +: OP_WIDTH];
                    a_next             = req_operand_a[pick*DATA_WIDTH +: DATA_WIDTH];
                    b_next             = req_operand_b[pick*DATA_WIDTH +: DATA_WIDTH];
                    req_ack_next[pick] = 1'b1;
                    rr_ptr_next        = (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
                    state_next         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_q <= OP_SUB) begin
                    operand_a_next = a_q;
                    operand_b_next = (op_q == OP_SUB) ? {~b_q[DATA_WIDTH-1], b_q[DATA_WIDTH-2:0]} : b_q;
                    case (op_q)
                        OP_EXP:  exponent_start_next = 1'b1;
                        OP_MUL:  mult_start_next     = 1'b1;
                        OP_DIV:  divide_start_next   = 1'b1;
                        default: add_start_next      = 1'b1;
                    endcase
                    timer_next = '0;
                    state_next = S_WAIT;
                end else begin
                    resp_valid_next[winner] = 1'b1;
                    resp_error_next         = 1'b1;
                    resp_data_next          = '0;
                    state_next              = S_RESPOND;
                end
            end
            S_WAIT: begin
                // Ready is checked before the timeout so a same-cycle completion is not lost.
                if (unit_ready) begin
                    resp_valid_next[winner] = 1'b1;
                    resp_error_next         = 1'b0;
                    resp_data_next          = unit_result;
                    state_next              = S_RESPOND;
                end else if (timer == TMR_LAST) begin
                    resp_valid_next[winner] = 1'b1;
                    resp_error_next         = 1'b1;
                    resp_data_next          = '0;
                    state_next              = S_RESPOND;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            S_RESPOND: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            rr_ptr         <= '0;
            winner         <= '0;
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            timer          <= '0;
            req_ack        <= '0;
            resp_valid     <= '0;
            resp_data      <= '0;
            resp_error     <= 1'b0;
            operand_a      <= '0;
            operand_b      <= '0;
            mult_start     <= 1'b0;
            add_start      <= 1'b0;
            divide_start   <= 1'b0;
            exponent_start <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            rr_ptr         <= rr_ptr_next;
            winner         <= winner_next;
            op_q           <= op_next;
            a_q            <= a_next;
            b_q            <= b_next;
            timer          <= timer_next;
            req_ack        <= req_ack_next;
            resp_valid     <= resp_valid_next;
            resp_data      <= resp_data_next;
            resp_error     <= resp_error_next;
            operand_a      <= operand_a_next;
            operand_b      <= operand_b_next;
            mult_start     <= mult_start_next;
            add_start      <= add_start_next;
            divide_start   <= divide_start_next;
            exponent_start <= exponent_start_next;
            busy           <= busy_next;
        end
    end

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Self-checking bench for fp_alu_arbiter: directed vector table, round-robin, reset and random traffic.
module tb_fp_alu_arbiter;

    localparam int T = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [11:0]  req_op;
    logic [127:0] req_operand_a, req_operand_b;
    logic [3:0]   req_ack, resp_valid;
    logic [31:0]  resp_data, operand_a, operand_b;
    logic         resp_error, busy;
    logic         mult_start, add_start, divide_start, exponent_start;
    logic [3:0]   rdy_v;
    logic [31:0]  res_b [4];

    logic [2:0]   op_v [4];
    logic [31:0]  a_v  [4];
    logic [31:0]  b_v  [4];
    int           total = 0;
    int           bad = 0;
    int           rr_model = 0;

    always #5 clock = ~clock;

    fp_alu_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .OP_WIDTH(3), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_op(req_op),
        .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
        .req_ack(req_ack), .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
        .mult_start(mult_start), .add_start(add_start), .divide_start(divide_start),
        .exponent_start(exponent_start),
        .operand_a(operand_a), .operand_b(operand_b),
        .mult_data_ready(rdy_v[0]), .add_data_ready(rdy_v[1]),
        .divide_data_ready(rdy_v[2]), .exponent_data_ready(rdy_v[3]),
        .mult_result(res_b[0]), .add_result(res_b[1]),
        .divide_result(res_b[2]), .exponent_result(res_b[3]),
        .busy(busy)
    );

    typedef struct {
        int          req;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          stray;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Unit index: 0 mult, 1 add, 2 divide, 3 exponent.
    function automatic int unit_of(input logic [2:0] op);
        case (op)
            3'd0:    return 3;
            3'd1:    return 0;
            3'd2:    return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int ref_pick(input logic [3:0] mask, input int ptr);
        for (int o = 0; o < 4; o++)
            if (mask[(ptr + o) % 4]) return (ptr + o) % 4;
        return -1;
    endfunction

    function automatic logic ref_err(input logic [2:0] op, input int lat);
        return (op > 3'd4) || (lat == 0) || (lat > T - 1);
    endfunction

    function automatic logic [3:0] starts();
        return {exponent_start, divide_start, add_start, mult_start};
    endfunction

    // Called just after an edge with the DUT idle; returns one cycle after it is idle again.
    task automatic serve(input logic [3:0] mask, input int lat, input logic [31:0] res, input int stray,
                         input logic [31:0] exp_d, input logic exp_e, output logic [3:0] ack_seen);
        int w, u, su, j_exp;
        bit done;
        logic [2:0] op;
        w = ref_pick(mask, rr_model);
        req_valid = mask;
        for (int i = 0; i < 4; i++) begin
            req_op[i*3 +: 3]          = op_v[i];
            req_operand_a[i*32 +: 32] = a_v[i];
            req_operand_b[i*32 +: 32] = b_v[i];
        end
        @(posedge clock); #1;
        ack_seen = req_ack;
        chk("req_ack", 32'(req_ack), 32'(1 << w));
        chk("busy_issue", 32'(busy), 32'd1);
        rr_model = (w + 1) % 4;
        req_valid[w]  = 1'b0;
        req_operand_a = {$urandom, $urandom, $urandom, $urandom};
        req_operand_b = {$urandom, $urandom, $urandom, $urandom};
        op = op_v[w];
        @(posedge clock); #1;
        chk("ack_drop", 32'(req_ack), 32'd0);
        if (op > 3'd4) begin
            chk("illegal_starts", 32'(starts()), 32'd0);
            chk("illegal_valid", 32'(resp_valid), 32'(1 << w));
            chk("illegal_error", 32'(resp_error), 32'(exp_e));
            chk("illegal_data", resp_data, exp_d);
        end else begin
            u  = unit_of(op);
            su = (u == 1) ? 0 : 1;
            chk("start", 32'(starts()), 32'(1 << u));
            chk("operand_a", operand_a, a_v[w]);
            chk("operand_b", operand_b, (op == 3'd4) ? (b_v[w] ^ 32'h8000_0000) : b_v[w]);
            for (int k = 0; k < 4; k++) res_b[k] = 32'hBAD0_0000 | 32'(k);
            res_b[u] = res;
            j_exp = (lat >= 1 && lat <= T - 1) ? lat + 1 : T;
            done = 1'b0;
            for (int j = 1; j <= T + 2 && !done; j++) begin
                @(posedge clock); #1;
                rdy_v = 4'b0;
                if (resp_valid != 4'b0) begin
                    done = 1'b1;
                    chk("resp_cycle", 32'(j), 32'(j_exp));
                    chk("resp_valid", 32'(resp_valid), 32'(1 << w));
                    chk("resp_error", 32'(resp_error), 32'(exp_e));
                    chk("resp_data", resp_data, exp_d);
                end else begin
                    chk("start_wait", 32'(starts()), 32'd0);
                    chk("busy_wait", 32'(busy), 32'd1);
                    if (j == lat) rdy_v[u] = 1'b1;
                    if (j == stray) rdy_v[su] = 1'b1;
                end
            end
            rdy_v = 4'b0;
            if (!done) chk("resp_timeout", 32'd0, 32'd1);
        end
        req_valid = 4'b0;
        @(posedge clock); #1;
        chk("resp_drop", 32'(resp_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [9];
        logic [3:0]  ack;
        int          order [5] = '{0, 1, 2, 3, 0};
        logic [3:0]  mask;
        int          w, lat;
        logic [31:0] res;

        vecs[0] = '{0, 3'd1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3, 0, 32'h40C0_0000, 1'b0};
        vecs[1] = '{1, 3'd4, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 2, 0, 32'h3F80_0000, 1'b0};
        vecs[2] = '{2, 3'd2, 32'h4120_0000, 32'h4000_0000, 32'h40A0_0000, 0, 0, 32'h0,         1'b1};
        vecs[3] = '{3, 3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         1, 0, 32'h0,         1'b1};
        vecs[4] = '{0, 3'd1, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4, 2, 32'h4040_0000, 1'b0};
        vecs[5] = '{1, 3'd0, 32'h3F80_0000, 32'h0,         32'h402D_F854, 1, 0, 32'h402D_F854, 1'b0};
        vecs[6] = '{2, 3'd3, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 7, 3, 32'h4000_0000, 1'b0};
        vecs[7] = '{3, 3'd2, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 8, 0, 32'h0,         1'b1};
        vecs[8] = '{0, 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1, 0, 32'h0,         1'b1};

        reset = 1'b1;
        req_valid = 4'b0; req_op = '0; req_operand_a = '0; req_operand_b = '0;
        rdy_v = 4'b0;
        for (int k = 0; k < 4; k++) begin
            res_b[k] = 32'h0; op_v[k] = 3'd1; a_v[k] = 32'h0; b_v[k] = 32'h0;
        end
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_starts", 32'(starts()), 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_error", 32'(resp_error), 32'd0);
        chk("rst_opa", operand_a, 32'd0);
        chk("rst_opb", operand_b, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        rr_model = 0;

        // All four requesters keep asking; grants must rotate 0,1,2,3,0.
        for (int n = 0; n < 5; n++) begin
            a_v[n % 4] = 32'(n); b_v[n % 4] = 32'(n + 10);
            serve(4'b1111, 2, 32'hC000_0000 | 32'(n), 0, 32'hC000_0000 | 32'(n), 1'b0, ack);
            chk("rr_order", 32'(ack), 32'(1 << order[n]));
        end

        foreach (vecs[i]) begin
            op_v[vecs[i].req] = vecs[i].op;
            a_v[vecs[i].req]  = vecs[i].a;
            b_v[vecs[i].req]  = vecs[i].b;
            serve(4'(1 << vecs[i].req), vecs[i].lat, vecs[i].res, vecs[i].stray,
                  vecs[i].exp_d, vecs[i].exp_e, ack);
        end

        // Reset while waiting on the multiplier abandons the operation silently.
        op_v[0] = 3'd1; a_v[0] = 32'h4000_0000; b_v[0] = 32'h4000_0000;
        while (rr_model != 0) begin
            op_v[rr_model] = 3'd1;
            serve(4'(1 << rr_model), 1, 32'h1, 0, 32'h1, 1'b0, ack);
        end
        req_valid = 4'b0001;
        req_op[2:0] = 3'd1;
        req_operand_a[31:0] = a_v[0];
        req_operand_b[31:0] = b_v[0];
        @(posedge clock); #1;
        chk("pre_rst_ack", 32'(req_ack), 32'd1);
        req_valid = 4'b0;
        @(posedge clock); #1;
        chk("pre_rst_start", 32'(mult_start), 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midrst_ack", 32'(req_ack), 32'd0);
        chk("midrst_valid", 32'(resp_valid), 32'd0);
        chk("midrst_starts", 32'(starts()), 32'd0);
        chk("midrst_data", resp_data, 32'd0);
        chk("midrst_error", 32'(resp_error), 32'd0);
        chk("midrst_opa", operand_a, 32'd0);
        chk("midrst_opb", operand_b, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        rr_model = 0;
        rdy_v[0] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clock); #1;
            chk("postrst_valid", 32'(resp_valid), 32'd0);
        end
        rdy_v = 4'b0;
        op_v[3] = 3'd1;
        serve(4'b1001, 2, 32'h3F80_0000, 0, 32'h3F80_0000, 1'b0, ack);
        chk("postrst_winner", 32'(ack), 32'd1);

        // Random traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) begin
                op_v[k] = 3'($urandom_range(0, 7));
                a_v[k]  = $urandom;
                b_v[k]  = $urandom;
            end
            lat = $urandom_range(0, 9);
            res = $urandom;
            w   = ref_pick(mask, rr_model);
            serve(mask, lat, res, $urandom_range(0, 6),
                  ref_err(op_v[w], lat) ? 32'h0 : res, ref_err(op_v[w], lat), ack);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
